// File: rtl/num_param.sv
// Parametrised synchronous modulo-MODULUS up/down counter with prescaler,
// parallel load, wrap/saturate mode, terminal-count pulse and sticky overflow.
module num_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE = PW'(1);

    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_next;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_next;

    // Next-state: load beats stepping; a step only fires when the prescaler
    // completes its period. A limit step sets ovf even if clr_ovf is high.
    always_comb begin
        q_next   = q;
        pre_next = pre_cnt;
        tc_next  = 1'b0;
        ovf_next = ovf & ~clr_ovf;
        if (load) begin
            q_next   = (d > Q_MAX) ? Q_MAX : d;
            pre_next = '0;
        end else if (en) begin
            if (pre_cnt == PRE_MAX) begin
                pre_next = '0;
                if (up) begin
                    if (q == Q_MAX) begin
                        tc_next  = 1'b1;
                        ovf_next = 1'b1;
                        q_next   = sat ? q : '0;
                    end else begin
                        q_next = q + Q_ONE;
                    end
                end else begin
                    if (q == '0) begin
                        tc_next  = 1'b1;
                        ovf_next = 1'b1;
                        q_next   = sat ? q : Q_MAX;
                    end else begin
                        q_next = q - Q_ONE;
                    end
                end
            end else begin
                pre_next = pre_cnt + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            q       <= q_next;
            pre_cnt <= pre_next;
            tc      <= tc_next;
            ovf     <= ovf_next;
        end
    end

endmodule

// File: tb/tb_num_param.sv
// Self-checking bench: three counter configurations driven in parallel and
// compared every cycle against an integer reference model.
module tb_num_param;

    localparam int N = 3;
    localparam int MODS [N] = '{10, 10, 16};
    localparam int PRES [N] = '{1, 3, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic       clr_ovf = 1'b0;

    logic [3:0] q_o   [N];
    logic       tc_o  [N];
    logic       ovf_o [N];

    int mq   [N];
    int mpc  [N];
    int mtc  [N];
    int movf [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    num_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .clr_ovf(clr_ovf), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

    num_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .clr_ovf(clr_ovf), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

    num_param #(.WIDTH(4), .MODULUS(16), .PRESCALE(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .clr_ovf(clr_ovf), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

    // Reference model: one rising edge worth of the counting rules, in integers.
    task automatic model_edge();
        int lim;
        for (int i = 0; i < N; i++) begin
            lim = 0;
            if (reset) begin
                mq[i] = 0; mpc[i] = 0; mtc[i] = 0; movf[i] = 0;
            end else if (load) begin
                mq[i]  = (int'(d) > MODS[i] - 1) ? MODS[i] - 1 : int'(d);
                mpc[i] = 0;
                mtc[i] = 0;
                if (clr_ovf) movf[i] = 0;
            end else begin
                if (en) begin
                    mpc[i] = mpc[i] + 1;
                    if (mpc[i] == PRES[i]) begin
                        mpc[i] = 0;
                        if (up) begin
                            if (mq[i] == MODS[i] - 1) begin
                                lim = 1;
                                if (!sat) mq[i] = 0;
                            end else mq[i] = mq[i] + 1;
                        end else begin
                            if (mq[i] == 0) begin
                                lim = 1;
                                if (!sat) mq[i] = MODS[i] - 1;
                            end else mq[i] = mq[i] - 1;
                        end
                    end
                end
                mtc[i] = lim;
                if (lim == 1) movf[i] = 1;
                else if (clr_ovf) movf[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; en = 1'b1; d = 4'd7;
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (q_o[i] !== 4'd0 || tc_o[i] !== 1'b0 || ovf_o[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: q=%0d tc=%b ovf=%b required q=0 tc=0 ovf=0",
                         i, q_o[i], tc_o[i], ovf_o[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (q_o[0] !== exp_q[c][3:0] || tc_o[0] !== (c == 9) || ovf_o[0] !== (c >= 9)) begin
                errors++;
                $display("[TB] FAIL wrap_up cycle %0d: q=%0d tc=%b ovf=%b required q=%0d tc=%b ovf=%b",
                         c, q_o[0], tc_o[0], ovf_o[0], exp_q[c], c == 9, c >= 9);
            end
            for (int i = 1; i < N; i++) begin
                checks++;
                if (q_o[i] !== mq[i][3:0] || tc_o[i] !== mtc[i][0] || ovf_o[i] !== movf[i][0]) begin
                    errors++;
                    $display("[TB] FAIL wrap_up model[%0d]: q=%0d tc=%b ovf=%b required q=%0d tc=%0d ovf=%0d",
                             i, q_o[i], tc_o[i], ovf_o[i], mq[i], mtc[i], movf[i]);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_sat();
        int exp_q [5] = '{1, 0, 0, 0, 0};
        load = 1'b1; d = 4'd2;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (q_o[0] !== exp_q[c][3:0] || tc_o[0] !== (c >= 2) || ovf_o[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL down_sat cycle %0d: q=%0d tc=%b ovf=%b required q=%0d tc=%b ovf=1",
                         c, q_o[0], tc_o[0], ovf_o[0], exp_q[c], c >= 2);
            end
        end
        en = 1'b0; sat = 1'b0;
    endtask

    task automatic test_prescaler();
        int enabled = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0; up = 1'b1;
        for (int c = 0; c < 11; c++) begin
            en = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            if (en) enabled++;
            tick();
            checks++;
            if (q_o[1] !== 4'(enabled / 3)) begin
                errors++;
                $display("[TB] FAIL prescaler cycle %0d: q=%0d required %0d", c, q_o[1], enabled / 3);
            end
            checks++;
            if (q_o[2] !== mq[2][3:0]) begin
                errors++;
                $display("[TB] FAIL prescaler2 cycle %0d: q=%0d required %0d", c, q_o[2], mq[2]);
            end
        end
        checks++;
        if (q_o[1] !== 4'd3) begin
            errors++;
            $display("[TB] FAIL prescaler_final: q=%0d required 3", q_o[1]);
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; en = 1'b1; d = 4'hF;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (q_o[i] !== 4'(MODS[i] - 1) || tc_o[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_clamp[%0d]: q=%0d tc=%b required q=%0d tc=0",
                         i, q_o[i], tc_o[i], MODS[i] - 1);
            end
        end
        // Prescaler must have been cleared: dut_b steps only on the third enabled cycle.
        load = 1'b0; sat = 1'b1; up = 1'b0;
        tick(); tick();
        checks++;
        if (q_o[1] !== 4'd9) begin
            errors++;
            $display("[TB] FAIL load_prescale_early: q=%0d required 9", q_o[1]);
        end
        tick();
        checks++;
        if (q_o[1] !== 4'd8) begin
            errors++;
            $display("[TB] FAIL load_prescale_step: q=%0d required 8", q_o[1]);
        end
        load = 1'b1; reset = 1'b1; d = 4'd5;
        tick();
        load = 1'b0; reset = 1'b0; en = 1'b0; sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (q_o[i] !== 4'd0) begin
                errors++;
                $display("[TB] FAIL load_vs_reset[%0d]: q=%0d required 0", i, q_o[i]);
            end
        end
    endtask

    task automatic test_ovf_clear();
        load = 1'b1; d = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        tick();
        checks++;
        if (q_o[0] !== 4'd0 || ovf_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: q=%0d ovf=%b required q=0 ovf=1", q_o[0], ovf_o[0]);
        end
        clr_ovf = 1'b1;
        tick();
        checks++;
        if (ovf_o[0] !== 1'b0 || q_o[0] !== 4'd1) begin
            errors++;
            $display("[TB] FAIL ovf_clear: q=%0d ovf=%b required q=1 ovf=0", q_o[0], ovf_o[0]);
        end
        clr_ovf = 1'b0; load = 1'b1; d = 4'd9;
        tick();
        load = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf_o[0] !== 1'b1 || tc_o[0] !== 1'b1 || q_o[0] !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ovf_race: q=%0d tc=%b ovf=%b required q=0 tc=1 ovf=1",
                     q_o[0], tc_o[0], ovf_o[0]);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int c = 0; c < 22; c++) tick();
        checks++;
        if (q_o[1] !== 4'd7) begin
            errors++;
            $display("[TB] FAIL reset_mid_setup: q=%0d required 7", q_o[1]);
        end
        reset = 1'b1; load = 1'b1; d = 4'd3;
        tick();
        reset = 1'b0; load = 1'b0;
        checks++;
        if (q_o[1] !== 4'd0 || tc_o[1] !== 1'b0 || ovf_o[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: q=%0d tc=%b ovf=%b required 0 0 0", q_o[1], tc_o[1], ovf_o[1]);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (q_o[1] !== 4'(c / 3)) begin
                errors++;
                $display("[TB] FAIL reset_mid_restart cycle %0d: q=%0d required %0d", c, q_o[1], c / 3);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 9) == 0);
            d       = 4'($urandom_range(0, 15));
            en      = ($urandom_range(0, 3) != 0);
            up      = 1'($urandom);
            sat     = 1'($urandom);
            clr_ovf = ($urandom_range(0, 7) == 0);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (q_o[i] !== mq[i][3:0] || tc_o[i] !== mtc[i][0] || ovf_o[i] !== movf[i][0]) begin
                    errors++;
                    $display("[TB] FAIL random cycle %0d dut %0d: q=%0d tc=%b ovf=%b required q=%0d tc=%0d ovf=%0d",
                             c, i, q_o[i], tc_o[i], ovf_o[i], mq[i], mtc[i], movf[i]);
                end
            end
        end
        reset = 1'b0; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mq[i] = 0; mpc[i] = 0; mtc[i] = 0; movf[i] = 0;
        end
        test_reset();
        test_wrap_up();
        test_down_sat();
        test_prescaler();
        test_load_clamp();
        test_ovf_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/num_param.md
Name: num_param

Overview:
- Parametrised synchronous successor to the 4-bit binary ripple counter.
- Fully synchronous modulo-N up/down counter:
  - programmable width and modulus;
  - clock prescaler;
  - parallel load;
  - wrap or saturate mode;
  - terminal-count pulse and sticky overflow flag.
- Used as the general-purpose counting/timebase element in the design. Replaces chains of T flip-flops clocked from counter outputs.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 1, enabled clock cycles per count step. Must be >= 1. PRESCALE=1 means every enabled cycle steps.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; prescaler advances only when high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- sat  input  1  mode: 1 = saturate at limit, 0 = wrap modulo MODULUS.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- clr_ovf  input  1  clears sticky overflow flag.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset (synchronous, active-high, checked at rising edge of clk):
  - q=0, tc=0, ovf=0, prescaler=0.
  - Reset overrides all other inputs.
- Priority per edge: reset > load > step > hold.
- Load:
  - q <= d if d <= MODULUS-1, else q <= MODULUS-1 (clamp).
  - Prescaler cleared to 0.
  - tc <= 0; ovf unchanged (except by clr_ovf).
  - The en value in a load cycle is ignored.
- Prescaler:
  - Internal counter of width clog2(PRESCALE), max(1).
  - Each cycle with en=1 and no load: if prescaler == PRESCALE-1, a step occurs and the prescaler goes to 0; otherwise the prescaler increments.
  - en=0 freezes the prescaler and q.
- Step, non-limit case (up=1 and q < MODULUS-1, or up=0 and q > 0): q <= q+1 or q-1; tc <= 0.
- Step, limit case (up=1 and q == MODULUS-1, or up=0 and q == 0):
  - sat=0: q wraps to 0 (up) or MODULUS-1 (down).
  - sat=1: q holds.
  - Either mode: tc <= 1 for exactly one cycle; ovf <= 1.
- tc:
  - Deasserted in every cycle without a limit step.
  - Back-to-back limit steps (sat=1, PRESCALE=1, en held) keep tc high on consecutive cycles.
- ovf:
  - Set by any limit step, cleared by clr_ovf.
  - If a set event and clr_ovf coincide, set wins (ovf=1).
- Direction change (up toggled) mid-count takes effect on the next step. No extra latency, no prescaler reset.
- Arithmetic is WIDTH-bit unsigned. With MODULUS < 2**WIDTH, q never exceeds MODULUS-1 by any path.
- Latency: q, tc, ovf all update on the same edge as the step decision; no combinational path from inputs to outputs.
- Reset mid-count or mid-prescale: q and prescaler return to 0 on that edge; the count restarts a full PRESCALE period later.

Test Plan:
- Wrap up, WIDTH=4, MODULUS=10, PRESCALE=1:
  - Stimulus: reset 1 cycle, then en=1, up=1, sat=0 for 12 cycles.
  - Required: q = 1..9, 0, 1, 2; tc high only in the cycle q=0 appears; ovf=1 from then on.
- Down/saturate, MODULUS=10:
  - Stimulus: load d=2, then en=1, up=0, sat=1 for 5 cycles.
  - Required: q = 1, 0, 0, 0, 0; tc high on the three hold cycles; ovf=1.
- Prescaler, PRESCALE=3:
  - Stimulus: en=1, up=1 for 9 cycles from q=0, with en=0 inserted for 2 cycles after cycle 4.
  - Required: q steps only on every third enabled cycle (q=3 after 11 clocks); frozen while en=0.
- Load priority and clamp, MODULUS=10:
  - Stimulus: load=1 with en=1, d=4'hF.
  - Required: q=9, tc=0, prescaler cleared.
  - Stimulus: next cycle load=1, d=5 with reset=1.
  - Required: q=0.
- Overflow clear race:
  - Stimulus: with ovf=1, assert clr_ovf on a non-limit cycle.
  - Required: ovf=0.
  - Stimulus: assert clr_ovf in the same cycle as a wrap 9->0.
  - Required: ovf stays 1.
- Reset mid-operation:
  - Stimulus: at q=7, prescaler=1 (PRESCALE=3), assert reset one cycle with load=1 and en=1.
  - Required: q=0, tc=0, ovf=0; first step occurs 3 enabled cycles after reset is released.
